// File: rtl/tsp_program_loader.sv
// Program loader: packs 32-bit ARM words into 64-bit TSP instructions, writes them
// sequentially into instruction memory and optionally launches the core at the base.
module tsp_program_loader #(
  parameter int unsigned IMEM_AW = 10
) (
  input  logic               GCLK,
  input  logic               reset_rtl_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [31:0]        s_data,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [63:0]        imem_wdata,
  output logic               core_start,
  output logic [IMEM_AW-1:0] core_pc,
  input  logic               core_done,
  output logic               load_done,
  output logic               busy,
  output logic               hdr_err
);

  localparam int unsigned LEN_W = 15;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_LO = 3'd1,
    ST_LOAD_HI = 3'd2,
    ST_START   = 3'd3,
    ST_RUN     = 3'd4
  } state_e;

  state_e             state_q;
  logic               s_ready_q;
  logic               busy_q;
  logic               hdr_err_q;
  logic               imem_we_q;
  logic [IMEM_AW-1:0] imem_addr_q;
  logic [63:0]        imem_wdata_q;
  logic               core_start_q;
  logic [IMEM_AW-1:0] core_pc_q;
  logic               load_done_q;
  logic [IMEM_AW-1:0] base_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;
  logic               auto_q;
  logic [31:0]        lo_q;

  logic               xfer_c;
  logic               last_c;
  logic [LEN_W-1:0]   hdr_len_c;

  assign xfer_c    = s_valid & s_ready_q;
  assign last_c    = (cnt_q == (len_q - LEN_W'(1)));
  assign hdr_len_c = s_data[16 +: LEN_W];

  // Ready and busy are registered from the next state so they track the FSM exactly.
  always_ff @(posedge GCLK or negedge reset_rtl_n) begin
    if (!reset_rtl_n) begin
      state_q      <= ST_IDLE;
      s_ready_q    <= 1'b0;
      busy_q       <= 1'b0;
      hdr_err_q    <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_start_q <= 1'b0;
      core_pc_q    <= '0;
      load_done_q  <= 1'b0;
      base_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      auto_q       <= 1'b0;
      lo_q         <= '0;
    end else begin
      imem_we_q    <= 1'b0;
      load_done_q  <= 1'b0;
      core_start_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          s_ready_q <= 1'b1;
          if (xfer_c) begin
            if (hdr_len_c == '0) begin
              hdr_err_q <= 1'b1;
            end else begin
              hdr_err_q <= 1'b0;
              base_q    <= s_data[IMEM_AW-1:0];
              len_q     <= hdr_len_c;
              auto_q    <= s_data[31];
              cnt_q     <= '0;
              busy_q    <= 1'b1;
              state_q   <= ST_LOAD_LO;
            end
          end
        end
        ST_LOAD_LO: begin
          if (xfer_c) begin
            lo_q    <= s_data;
            state_q <= ST_LOAD_HI;
          end
        end
        ST_LOAD_HI: begin
          if (xfer_c) begin
            imem_we_q    <= 1'b1;
            imem_addr_q  <= base_q + IMEM_AW'(cnt_q);
            imem_wdata_q <= {s_data, lo_q};
            cnt_q        <= cnt_q + LEN_W'(1);
            if (!last_c) begin
              state_q <= ST_LOAD_LO;
            end else begin
              load_done_q <= 1'b1;
              if (auto_q) begin
                s_ready_q <= 1'b0;
                state_q   <= ST_START;
              end else begin
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end
            end
          end
        end
        ST_START: begin
          core_start_q <= 1'b1;
          core_pc_q    <= base_q;
          state_q      <= ST_RUN;
        end
        ST_RUN: begin
          // A done coinciding with the start pulse belongs to no run of ours.
          if (core_done && !core_start_q) begin
            s_ready_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          s_ready_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_ready    = s_ready_q;
  assign busy       = busy_q;
  assign hdr_err    = hdr_err_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_start = core_start_q;
  assign core_pc    = core_pc_q;
  assign load_done  = load_done_q;

endmodule
